ex_hazard_ctrl: RTL and testbench
=================================

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, range 2..15: total EX occupancy in cycles of a MUL (funct 6'b000010).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  5  ID source register A
- id_rt  in  5  ID source register B
- id_uses_rt  in  1  ID instruction reads rt
- id_aluop  in  2  ID ALUOp: 00 LW/SW/ADDI, 01 BEQ, 10 RType
- id_funct  in  6  ID funct: 000000 ADD, 000001 SUB, 000010 MUL
- ex_mem_read  in  1  EX holds a load
- ex_reg_write  in  1  EX writes a register
- ex_rd  in  5  EX destination
- mem_reg_write  in  1  MEM writes a register
- mem_rd  in  5  MEM destination
- ex_branch_taken  in  1  EX branch AND zero
- stall_flag  out  1  freeze PC/IF/ID/EX capture
- flush_id  out  1  squash the ID instruction
- fwd_a  out  2  operand-A source: 00 regfile, 01 EX result, 10 MEM result
- fwd_b  out  2  operand-B source, same encoding
- mul_busy  out  1  multiplier occupied
- stall_count  out  16  saturating count of stalled cycles

Function
REQ-003 SHALL implement states IDLE, MUL_WAIT, LOAD_STALL, FLUSH, held in a registered state variable.
REQ-004 SHALL define load-use hazard = id_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-005 SHALL define mul_issue = id_valid & id_aluop==2'b10 & id_funct==6'b000010 & ~stall_flag & ~ex_branch_taken.
REQ-006 In IDLE, SHALL apply, in priority order: ex_branch_taken -> FLUSH; load-use -> LOAD_STALL; mul_issue -> MUL_WAIT with counter loaded to MUL_CYCLES-1; else stay IDLE.
REQ-007 In LOAD_STALL, SHALL drive stall_flag=1 for exactly one cycle, then return to IDLE.
REQ-008 In MUL_WAIT, SHALL drive stall_flag=1 and mul_busy=1, and decrement the counter each cycle; on the cycle the counter reaches 0, SHALL go to IDLE.
REQ-009 Total stall for one MUL SHALL be MUL_CYCLES-1 cycles after the issue cycle.
REQ-010 In FLUSH, SHALL drive flush_id=1 and stall_flag=0 for exactly one cycle, then return to IDLE.
REQ-011 stall_flag, flush_id and mul_busy SHALL be registered outputs decoded from state, never high in IDLE.
REQ-012 ex_branch_taken SHALL be ignored while stall_flag=1.
REQ-013 A branch coinciding with a load-use hazard SHALL take FLUSH, with no stall.
REQ-014 fwd_a SHALL be combinational: 01 if ex_reg_write & ex_rd!=0 & ex_rd==id_rs; else 10 if mem_reg_write & mem_rd!=0 & mem_rd==id_rs; else 00.
REQ-015 fwd_b SHALL use the same rule against id_rt, and SHALL be 00 when id_uses_rt=0.
REQ-016 EX forwarding SHALL take priority over MEM forwarding.
REQ-017 Register 0 SHALL never be forwarded.
REQ-018 fwd_a and fwd_b SHALL be 00 when id_valid=0.
REQ-019 stall_count SHALL increment on each rising edge where stall_flag=1, and saturate at 16'hFFFF without wrapping.
REQ-020 A MUL immediately following a completed MUL SHALL be accepted on the first IDLE cycle.
REQ-021 Back-to-back MULs SHALL never overlap.

Reset
REQ-022 While reset=1, asynchronously and immediately: state=IDLE, counter=0, stall_flag=0, flush_id=0, mul_busy=0, stall_count=0.
REQ-023 Reset asserted mid-MUL_WAIT or mid-LOAD_STALL SHALL abort the operation, with no residual stall after release.
REQ-024 The first state transition after reset SHALL occur on the first rising clk edge with reset=0.

Verification
REQ-025 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_valid=1 -> stall_flag=1 for exactly 1 cycle; stall_count=1.
REQ-026 MUL, MUL_CYCLES=4: id_aluop=10, id_funct=000010 issued -> stall_flag and mul_busy high for 3 cycles, then low; a second MUL issued right after gives another 3-cycle stall.
REQ-027 Forwarding: ex_rd=mem_rd=7, both reg_write=1, id_rs=7 -> fwd_a=01; ex_rd=0, id_rt=0, id_uses_rt=1 -> fwd_b=00; mem match only -> 10.
REQ-028 Branch: ex_branch_taken=1 together with a load-use hazard -> flush_id=1 for 1 cycle, stall_flag=0.
REQ-029 Reset asserted 1 cycle into MUL_WAIT -> all outputs 0 immediately (before the next edge); stall_count=0; IDLE after release.
REQ-030 Saturation: hold a repeated MUL stream past 65535 stalled cycles -> stall_count remains 16'hFFFF.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard controller: load-use stall, multi-cycle MUL, branch flush, forwarding
module ex_hazard_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [1:0]  id_aluop,
    input  logic [5:0]  id_funct,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        ex_branch_taken,
    output logic        stall_flag,
    output logic        flush_id,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mul_busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MUL_WAIT   = 2'd1,
        LOAD_STALL = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       load_use;
    logic       mul_issue;

    assign load_use = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    assign mul_issue = id_valid & (id_aluop == 2'b10) & (id_funct == 6'b000010) &
                       ~stall_flag & ~ex_branch_taken;

    // Next-state and MUL countdown; the branch input is only looked at from IDLE,
    // so it is naturally ignored while any stall state is active.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (ex_branch_taken) begin
                    state_next = FLUSH;
                end else if (load_use) begin
                    state_next = LOAD_STALL;
                end else if (mul_issue) begin
                    state_next = MUL_WAIT;
                    cnt_next   = MUL_LOAD;
                end
            end
            MUL_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            LOAD_STALL: state_next = IDLE;
            FLUSH:      state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // State, counter and the registered control outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            stall_flag <= 1'b0;
            flush_id   <= 1'b0;
            mul_busy   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            stall_flag <= (state_next == MUL_WAIT) | (state_next == LOAD_STALL);
            flush_id   <= (state_next == FLUSH);
            mul_busy   <= (state_next == MUL_WAIT);
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (stall_flag && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Operand-A forwarding: EX result wins over MEM, r0 never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (id_valid) begin
            if (ex_reg_write && (ex_rd != 5'd0) && (ex_rd == id_rs)) begin
                fwd_a = 2'b01;
            end else if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rs)) begin
                fwd_a = 2'b10;
            end
        end
    end

    // Operand-B forwarding: same rule, only when the instruction actually reads rt.
    always_comb begin
        fwd_b = 2'b00;
        if (id_valid && id_uses_rt) begin
            if (ex_reg_write && (ex_rd != 5'd0) && (ex_rd == id_rt)) begin
                fwd_b = 2'b01;
            end else if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == id_rt)) begin
                fwd_b = 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        ex_branch_taken;
    logic        stall_flag;
    logic        flush_id;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mul_busy;
    logic [15:0] stall_count;

    logic        sat_valid;
    logic        sat_stall;
    logic        sat_flush;
    logic [1:0]  sat_fwd_a;
    logic [1:0]  sat_fwd_b;
    logic        sat_busy;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_aluop(id_aluop), .id_funct(id_funct),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .ex_branch_taken(ex_branch_taken),
        .stall_flag(stall_flag), .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mul_busy(mul_busy), .stall_count(stall_count)
    );

    ex_hazard_ctrl #(.MUL_CYCLES(15)) sat_dut (
        .clk(clk), .reset(reset), .id_valid(sat_valid), .id_rs(5'd0), .id_rt(5'd0),
        .id_uses_rt(1'b0), .id_aluop(2'b10), .id_funct(6'b000010),
        .ex_mem_read(1'b0), .ex_reg_write(1'b0), .ex_rd(5'd0),
        .mem_reg_write(1'b0), .mem_rd(5'd0), .ex_branch_taken(1'b0),
        .stall_flag(sat_stall), .flush_id(sat_flush), .fwd_a(sat_fwd_a), .fwd_b(sat_fwd_b),
        .mul_busy(sat_busy), .stall_count(sat_count)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        ex_mr;
        logic        ex_rw;
        logic [4:0]  ex_rd;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic        br;
        logic [1:0]  e_fa;
        logic [1:0]  e_fb;
        logic        e_stall;
        logic        e_flush;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic u,
        input logic [1:0] op, input logic [5:0] fn, input logic emr, input logic erw,
        input logic [4:0] erd, input logic mrw, input logic [4:0] mrd, input logic br,
        input logic [1:0] fa, input logic [1:0] fb, input logic st, input logic fl,
        input logic [15:0] cn);
        vec_t t;
        t.valid = v; t.rs = rs; t.rt = rt; t.uses_rt = u; t.aluop = op; t.funct = fn;
        t.ex_mr = emr; t.ex_rw = erw; t.ex_rd = erd; t.mem_rw = mrw; t.mem_rd = mrd;
        t.br = br; t.e_fa = fa; t.e_fb = fb; t.e_stall = st; t.e_flush = fl; t.e_cnt = cn;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        id_valid = t.valid; id_rs = t.rs; id_rt = t.rt; id_uses_rt = t.uses_rt;
        id_aluop = t.aluop; id_funct = t.funct; ex_mem_read = t.ex_mr;
        ex_reg_write = t.ex_rw; ex_rd = t.ex_rd; mem_reg_write = t.mem_rw;
        mem_rd = t.mem_rd; ex_branch_taken = t.br;
    endtask

    task automatic idle_inputs();
        apply(mk(0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        v  rs  rt  u  op     funct     emr erw erd mrw mrd br  fa     fb     st fl cnt
        tbl[0]  = mk(1, 7,  3,  1, 2'b10, 6'd0, 0, 1, 7, 1, 7, 0, 2'b01, 2'b00, 0, 0, 16'd0);
        tbl[1]  = mk(1, 0,  0,  1, 2'b10, 6'd0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        tbl[2]  = mk(1, 4,  9,  1, 2'b10, 6'd1, 0, 1, 2, 1, 4, 0, 2'b10, 2'b00, 0, 0, 16'd0);
        tbl[3]  = mk(1, 1,  9,  1, 2'b10, 6'd0, 0, 1, 9, 1, 9, 0, 2'b00, 2'b01, 0, 0, 16'd0);
        tbl[4]  = mk(1, 1,  9,  0, 2'b10, 6'd0, 0, 1, 9, 1, 9, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        tbl[5]  = mk(1, 6,  6,  1, 2'b10, 6'd0, 0, 0, 6, 1, 6, 0, 2'b10, 2'b10, 0, 0, 16'd0);
        tbl[6]  = mk(0, 6,  6,  1, 2'b10, 6'd0, 1, 1, 6, 1, 6, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        tbl[7]  = mk(1, 5,  0,  0, 2'b00, 6'd0, 1, 1, 5, 0, 0, 0, 2'b01, 2'b00, 1, 0, 16'd0);
        tbl[8]  = mk(1, 1,  2,  0, 2'b01, 6'd0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 16'd1);
        tbl[9]  = mk(1, 2,  8,  1, 2'b10, 6'd0, 1, 1, 8, 0, 0, 0, 2'b00, 2'b01, 1, 0, 16'd1);
        tbl[10] = mk(0, 0,  0,  0, 2'b00, 6'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd2);
        tbl[11] = mk(1, 0,  0,  0, 2'b00, 6'd0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd2);
        tbl[12] = mk(1, 5,  0,  0, 2'b01, 6'd0, 1, 1, 5, 0, 0, 1, 2'b01, 2'b00, 0, 1, 16'd2);
        tbl[13] = mk(0, 0,  0,  0, 2'b00, 6'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd2);
        tbl[14] = mk(1, 1,  5,  0, 2'b00, 6'd0, 1, 1, 5, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd2);

        reset = 1'b1;
        sat_valid = 1'b0;
        idle_inputs();
        tick();
        chk("rst_stall", {15'd0, stall_flag}, 16'd0);
        chk("rst_flush", {15'd0, flush_id}, 16'd0);
        chk("rst_busy", {15'd0, mul_busy}, 16'd0);
        chk("rst_count", stall_count, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_fwd_a", i), {14'd0, fwd_a}, {14'd0, tbl[i].e_fa});
            chk($sformatf("v%0d_fwd_b", i), {14'd0, fwd_b}, {14'd0, tbl[i].e_fb});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_stall", i), {15'd0, stall_flag}, {15'd0, tbl[i].e_stall});
            chk($sformatf("v%0d_flush", i), {15'd0, flush_id}, {15'd0, tbl[i].e_flush});
            chk($sformatf("v%0d_busy", i), {15'd0, mul_busy}, 16'd0);
            chk($sformatf("v%0d_count", i), stall_count, tbl[i].e_cnt);
        end

        // Held MUL in ID: 3 stalled cycles, one IDLE issue cycle, then 3 more.
        apply(mk(1, 3, 4, 1, 2'b10, 6'b000010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            ex_branch_taken = (k == 2);
            tick();
            chk($sformatf("mul%0d_stall", k), {15'd0, stall_flag}, {15'd0, (k % 4) != 0});
            chk($sformatf("mul%0d_busy", k), {15'd0, mul_busy}, {15'd0, (k % 4) != 0});
            chk($sformatf("mul%0d_flush", k), {15'd0, flush_id}, 16'd0);
        end
        ex_branch_taken = 1'b0;
        chk("mul_count", stall_count, 16'd8);

        // Reset one cycle into MUL_WAIT clears outputs without waiting for a clock edge.
        tick();
        chk("rmul_stall0", {15'd0, stall_flag}, 16'd1);
        tick();
        reset = 1'b1;
        #1;
        chk("rmul_stall", {15'd0, stall_flag}, 16'd0);
        chk("rmul_busy", {15'd0, mul_busy}, 16'd0);
        chk("rmul_flush", {15'd0, flush_id}, 16'd0);
        chk("rmul_count", stall_count, 16'd0);
        idle_inputs();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rmul_post_stall", {15'd0, stall_flag}, 16'd0);
            chk("rmul_post_busy", {15'd0, mul_busy}, 16'd0);
        end

        // Load-use right after release takes effect on the first edge.
        apply(mk(1, 5, 0, 0, 2'b00, 6'd0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("lu_stall", {15'd0, stall_flag}, 16'd1);
        idle_inputs();
        tick();
        chk("lu_stall_end", {15'd0, stall_flag}, 16'd0);
        chk("lu_count", stall_count, 16'd1);

        // Saturation on a MUL_CYCLES=15 instance fed a continuous MUL stream.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sat_valid = 1'b1;
        repeat (15000) @(posedge clk);
        #1;
        chk("sat_mid_count", sat_count, 16'd14000);
        repeat (55500) @(posedge clk);
        #1;
        chk("sat_count", sat_count, 16'hFFFF);
        repeat (30) @(posedge clk);
        #1;
        chk("sat_hold", sat_count, 16'hFFFF);
        chk("sat_flush", {15'd0, sat_flush}, 16'd0);
        chk("sat_fwd", {12'd0, sat_fwd_a, sat_fwd_b}, 16'd0);
        chk("sat_busy_eq_stall", {15'd0, sat_busy}, {15'd0, sat_stall});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
